dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Two-requester arbiter and sequencer in front of the RV32I pipeline's single-port data memory. Requester 0 is the pipeline MEM stage; requester 1 is the debug/loader port. The block accepts one transaction at a time from either requester and drives the memory's enable, load/store, func, byte-offset, address and write-data inputs for exactly one cycle. For loads it captures the memory's registered read data and returns a response. It also rejects misaligned or illegal accesses before they reach the memory.

## Interface
Parameters:
- D_WIDTH, 32, data width
- A_WIDTH, 8, word-address width

Ports (index i ∈ {0,1}; flattened buses, requester 0 in the low slice):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  requester i has a request
- req_ready  out  2  request i accepted this cycle
- req_we  in  2  1 = store, 0 = load
- req_func  in  6  3-bit funct3 per requester
- req_byteadd  in  4  2-bit byte offset per requester
- req_addr  in  2*A_WIDTH  word address
- req_wdata  in  2*D_WIDTH  store data
- rsp_valid  out  2  response pending for requester i
- rsp_ready  in  2  requester i consumes response
- rsp_rdata  out  D_WIDTH  load data, shared by both requesters
- rsp_err  out  1  misaligned or illegal access
- mem_en, mem_load_store  out  1 each  memory enable; 1 = store
- mem_func  out  3  funct3 to memory
- mem_byteadd  out  2  byte offset to memory
- mem_addr  out  A_WIDTH  word address to memory
- mem_wdata  out  D_WIDTH  write data to memory
- mem_rdata  in  D_WIDTH  memory read data, registered, valid the cycle after mem_en

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - If any req_valid, select a winner by round-robin. Pointer `last` holds the last granted index; the other index wins a tie.
  - Assert req_ready[winner] combinationally, latch all fields of the winner, set `owner` = winner and `last` = winner.
  - Legal request: next state ISSUE. Illegal request: next state RESP with err = 1.
- **Illegal request** (any of):
  - func ∉ {000, 001, 010, 100, 101}
  - store with func ∈ {100, 101}
  - func ∈ {001, 101} with byteadd = 11
  - func = 010 with byteadd ≠ 00
- **ISSUE**
  - Drive mem_en = 1 plus the latched fields for one cycle, then go to RESP.
- **RESP**
  - rsp_valid[owner] = 1.
  - rsp_rdata: load → mem_rdata, captured into a register on the first RESP cycle and held; store or error → 0.
  - rsp_err = latched error flag.
  - Hold all outputs until rsp_ready[owner]; then go to IDLE.
- Requesters must keep their fields stable while req_valid is high and not yet accepted. The arbiter never drops a pending response.
- Outside ISSUE, mem_en = 0 and every other mem_* output = 0.

## Timing
- Reset values: state IDLE, last = 1 (so requester 0 wins the first tie), req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, all mem_* = 0.
- Legal access accepted at cycle N: mem_en high at N+1, rsp_valid high from N+2.
- Error accepted at N: no mem_en, rsp_valid high from N+1.
- Minimum spacing between accepts is 3 cycles (legal) or 2 cycles (error). rsp_ready held high gives back-to-back transactions at that rate.
- req_ready is high only in IDLE and only for the winner, never for both requesters.
- A req_valid arriving while busy waits; the round-robin pointer guarantees it is granted next.
- Reset asserted mid-transaction: abort immediately to reset values. A store already in ISSUE may or may not have written memory; no response is produced.
- Widths:
  - A_WIDTH and D_WIDTH pass through unmodified.
  - No address arithmetic: mem_addr is the latched word address and mem_byteadd is the latched byte offset.

## Structure
- Shared package `dmem_pkg`:
  - funct3 constants FUNC_B = 000, FUNC_H = 001, FUNC_W = 010, FUNC_BU = 100, FUNC_HU = 101
  - FSM state encoding
  - function `is_illegal(we, func, byteadd)`
- Sub-module: `rr_arb2`, a combinational 2-way round-robin grant from (valid[1:0], last) → grant[1:0].
- The FSM, latches and response register stay in the top module.

## Test plan
- Requester 0 `sw` addr 0x10, wdata 0xDEADBEEF, then `lw` addr 0x10 → mem_en one cycle each; load response rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid at accept + 2.
- Both requesters valid continuously with loads → grants alternate 0, 1, 0, 1; neither requester waits more than one transaction.
- Requester 1 `lh` with byteadd = 11, and separately store with func = 100 → rsp_err = 1, rsp_valid at accept + 1, mem_en never asserted.
- `lbu` at byteadd = 10 after storing 0x80FF0000 → rsp_rdata = 0x000000FF. rsp_ready held low 4 cycles → data and rsp_valid stable throughout, no new grant.
- rst pulsed while in ISSUE → all outputs 0 the same cycle. After release with both requesters valid, requester 0 is granted first.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter: funct3 codes, FSM
// encoding and the access-legality check applied before a request reaches memory.
package dmem_pkg;

  localparam logic [2:0] FUNC_B  = 3'b000;
  localparam logic [2:0] FUNC_H  = 3'b001;
  localparam logic [2:0] FUNC_W  = 3'b010;
  localparam logic [2:0] FUNC_BU = 3'b100;
  localparam logic [2:0] FUNC_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Unsigned loads have no store counterpart; halves may not straddle a word.
  function automatic logic is_illegal(input logic       we,
                                      input logic [2:0] func,
                                      input logic [1:0] byteadd);
    logic bad;
    bad = 1'b1;
    case (func)
      FUNC_B:  bad = 1'b0;
      FUNC_H:  bad = (byteadd == 2'b11);
      FUNC_W:  bad = (byteadd != 2'b00);
      FUNC_BU: bad = we;
      FUNC_HU: bad = we || (byteadd == 2'b11);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: on a tie the index that was not
// granted last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the pipeline MEM stage and the debug/loader port onto the single
// data-memory port, one transaction at a time, and returns load data or errors.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0]           req_we,
  input  logic [5:0]           req_func,
  input  logic [3:0]           req_byteadd,
  input  logic [2*A_WIDTH-1:0] req_addr,
  input  logic [2*D_WIDTH-1:0] req_wdata,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [D_WIDTH-1:0]   rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_en,
  output logic                 mem_load_store,
  output logic [2:0]           mem_func,
  output logic [1:0]           mem_byteadd,
  output logic [A_WIDTH-1:0]   mem_addr,
  output logic [D_WIDTH-1:0]   mem_wdata,
  input  logic [D_WIDTH-1:0]   mem_rdata
);

  state_t               state, state_next;
  logic                 last_q, owner_q;
  logic                 we_q, err_q, first_q;
  logic [2:0]           func_q;
  logic [1:0]           byteadd_q;
  logic [A_WIDTH-1:0]   addr_q;
  logic [D_WIDTH-1:0]   wdata_q, rdata_q;

  logic [1:0]           grant;
  logic                 win;
  logic                 accept;
  logic                 win_we;
  logic [2:0]           win_func;
  logic [1:0]           win_byteadd;
  logic [A_WIDTH-1:0]   win_addr;
  logic [D_WIDTH-1:0]   win_wdata;
  logic                 win_err;

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .last  (last_q),
    .grant (grant)
  );

  assign win         = grant[1];
  assign accept      = (state == ST_IDLE) && (grant != 2'b00);
  assign win_we      = win ? req_we[1]                      : req_we[0];
  assign win_func    = win ? req_func[5:3]                  : req_func[2:0];
  assign win_byteadd = win ? req_byteadd[3:2]               : req_byteadd[1:0];
  assign win_addr    = win ? req_addr[2*A_WIDTH-1:A_WIDTH]  : req_addr[A_WIDTH-1:0];
  assign win_wdata   = win ? req_wdata[2*D_WIDTH-1:D_WIDTH] : req_wdata[D_WIDTH-1:0];
  assign win_err     = is_illegal(win_we, win_func, win_byteadd);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = win_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_next = ST_RESP;
      ST_RESP:  if (rsp_ready[owner_q]) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The handshake is combinational, so reset must also mask it while asserted.
  always_comb begin
    req_ready      = 2'b00;
    rsp_valid      = 2'b00;
    rsp_rdata      = '0;
    rsp_err        = 1'b0;
    mem_en         = 1'b0;
    mem_load_store = 1'b0;
    mem_func       = 3'b000;
    mem_byteadd    = 2'b00;
    mem_addr       = '0;
    mem_wdata      = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: req_ready = grant;
        ST_ISSUE: begin
          mem_en         = 1'b1;
          mem_load_store = we_q;
          mem_func       = func_q;
          mem_byteadd    = byteadd_q;
          mem_addr       = addr_q;
          mem_wdata      = wdata_q;
        end
        ST_RESP: begin
          rsp_valid = owner_q ? 2'b10 : 2'b01;
          rsp_err   = err_q;
          // Memory data is only valid in the first RESP cycle; later cycles replay the copy.
          if (!we_q && !err_q) rsp_rdata = first_q ? mem_rdata : rdata_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments and every register, including the data holding registers, takes the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
      func_q    <= 3'b000;
      byteadd_q <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state   <= state_next;
      first_q <= (state == ST_ISSUE);
      if (first_q) rdata_q <= mem_rdata;
      if (accept) begin
        owner_q   <= win;
        last_q    <= win;
        we_q      <= win_we;
        err_q     <= win_err;
        func_q    <= win_func;
        byteadd_q <= win_byteadd;
        addr_q    <= win_addr;
        wdata_q   <= win_wdata;
      end
    end
  end

endmodule
